// File: rtl/mcdf_pkg.sv
// Shared types and default parameters for the MCDF packet arbiter.
package mcdf_pkg;
  localparam int DEF_CH_NUM        = 3;
  localparam int DEF_FIFO_WIDE     = 32;
  localparam int DEF_FIFO_PTR_WIDE = 3;
  localparam int DEF_LEN_WIDE      = 3;
  localparam int PRIO_WIDE         = 2;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;
endpackage

// File: rtl/mcdf_rr_sel.sv
// Combinational selector: lowest priority value wins, ties resolved round-robin
// starting from the channel after last_gnt.
module mcdf_rr_sel
  import mcdf_pkg::*;
#(
  parameter int CH_NUM = DEF_CH_NUM
) (
  input  logic [CH_NUM-1:0]           elig,
  input  logic [PRIO_WIDE*CH_NUM-1:0] prio,
  input  logic [1:0]                  last_gnt,
  output logic                        gnt_valid,
  output logic [1:0]                  gnt
);
  logic [PRIO_WIDE-1:0] best;
  logic                 found;

  always_comb begin
    best      = '1;
    gnt_valid = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (elig[i] && (!gnt_valid || prio[i*PRIO_WIDE +: PRIO_WIDE] < best)) begin
        best      = prio[i*PRIO_WIDE +: PRIO_WIDE];
        gnt_valid = 1'b1;
      end
    end

    // walk last_gnt+1, last_gnt+2, ... and take the first channel at the best level
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= CH_NUM; k++) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (!found && elig[i] && prio[i*PRIO_WIDE +: PRIO_WIDE] == best &&
            ((int'(last_gnt) + k) % CH_NUM) == i) begin
          gnt   = 2'(i);
          found = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/mcdf_arbiter.sv
// Shares the formatter port among the slave FIFOs: arbitrates in IDLE, then
// streams one complete fixed-length packet from the granted FIFO in XFER.
module mcdf_arbiter
  import mcdf_pkg::*;
#(
  parameter int CH_NUM        = DEF_CH_NUM,
  parameter int FIFO_WIDE     = DEF_FIFO_WIDE,
  parameter int FIFO_PTR_WIDE = DEF_FIFO_PTR_WIDE,
  parameter int LEN_WIDE      = DEF_LEN_WIDE
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CH_NUM-1:0]                 ch_en,
  input  logic [PRIO_WIDE*CH_NUM-1:0]       ch_prio,
  input  logic [LEN_WIDE*CH_NUM-1:0]        ch_len,
  input  logic [(FIFO_PTR_WIDE+1)*CH_NUM-1:0] ch_level,
  input  logic [FIFO_WIDE*CH_NUM-1:0]       ch_data,
  output logic [CH_NUM-1:0]                 ch_pop,
  input  logic                              fmt_ready,
  output logic                              fmt_valid,
  output logic [FIFO_WIDE-1:0]              fmt_data,
  output logic [1:0]                        fmt_chid,
  output logic                              fmt_sop,
  output logic                              fmt_eop,
  output logic                              busy
);
  localparam int LVL_WIDE = FIFO_PTR_WIDE + 1;

  state_t              state, state_nx;
  logic [1:0]          gnt, gnt_nx, last_gnt, last_gnt_nx;
  logic [LEN_WIDE-1:0] word_idx, word_idx_nx, len_cnt, len_cnt_nx;
  logic [CH_NUM-1:0]   elig;
  logic                sel_valid;
  logic [1:0]          sel_gnt;
  logic                xfer_fire;

  // only complete packets are eligible
  always_comb begin
    elig = '0;
    for (int i = 0; i < CH_NUM; i++)
      elig[i] = ch_en[i] &&
                (int'(ch_level[i*LVL_WIDE +: LVL_WIDE]) >= int'(ch_len[i*LEN_WIDE +: LEN_WIDE]) + 1);
  end

  mcdf_rr_sel #(.CH_NUM(CH_NUM)) u_sel (
    .elig      (elig),
    .prio      (ch_prio),
    .last_gnt  (last_gnt),
    .gnt_valid (sel_valid),
    .gnt       (sel_gnt)
  );

  assign fmt_valid = (state == XFER);
  assign busy      = fmt_valid;
  assign fmt_chid  = fmt_valid ? gnt : 2'd0;
  assign fmt_data  = fmt_valid ? ch_data[int'(gnt)*FIFO_WIDE +: FIFO_WIDE] : '0;
  assign fmt_sop   = fmt_valid && (word_idx == '0);
  assign fmt_eop   = fmt_valid && (word_idx == len_cnt);
  // gated by rst_n so a reset edge never consumes a FIFO word
  assign xfer_fire = fmt_valid && fmt_ready && rst_n;

  always_comb begin
    ch_pop = '0;
    for (int i = 0; i < CH_NUM; i++)
      if (xfer_fire && int'(gnt) == i) ch_pop[i] = 1'b1;
  end

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    last_gnt_nx = last_gnt;
    word_idx_nx = word_idx;
    len_cnt_nx  = len_cnt;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          gnt_nx      = sel_gnt;
          len_cnt_nx  = ch_len[int'(sel_gnt)*LEN_WIDE +: LEN_WIDE];
          word_idx_nx = '0;
          state_nx    = XFER;
        end
      end
      XFER: begin
        if (xfer_fire) begin
          if (word_idx == len_cnt) begin
            last_gnt_nx = gnt;
            word_idx_nx = '0;
            state_nx    = IDLE;
          end else begin
            word_idx_nx = word_idx + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 2'd0;
      last_gnt <= 2'(CH_NUM - 1);
      word_idx <= '0;
      len_cnt  <= '0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      last_gnt <= last_gnt_nx;
      word_idx <= word_idx_nx;
      len_cnt  <= len_cnt_nx;
    end
  end
endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter with a simple show-ahead FIFO model per channel.
module tb_mcdf_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ch_en;
  logic [5:0]  ch_prio;
  logic [8:0]  ch_len;
  logic [11:0] ch_level;
  logic [95:0] ch_data;
  logic [2:0]  ch_pop;
  logic        fmt_ready;
  logic        fmt_valid;
  logic [31:0] fmt_data;
  logic [1:0]  fmt_chid;
  logic        fmt_sop, fmt_eop, busy;

  logic [31:0] mem [3][256];
  int wp [3];
  int rp [3];
  int exp_seq [3];
  int pops [3];
  int n_chk = 0;
  int n_err = 0;

  mcdf_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_prio(ch_prio), .ch_len(ch_len),
    .ch_level(ch_level), .ch_data(ch_data), .ch_pop(ch_pop), .fmt_ready(fmt_ready),
    .fmt_valid(fmt_valid), .fmt_data(fmt_data), .fmt_chid(fmt_chid),
    .fmt_sop(fmt_sop), .fmt_eop(fmt_eop), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] word(input int ch, input int seq);
    return {8'hA0 + 8'(ch), 8'h00, 16'(seq)};
  endfunction

  task automatic update_io();
    for (int i = 0; i < 3; i++) begin
      ch_level[i*4 +: 4] = 4'(wp[i] - rp[i]);
      ch_data[i*32 +: 32] = mem[i][rp[i] & 255];
    end
  endtask

  task automatic push(input int ch, input int n);
    for (int j = 0; j < n; j++) begin
      mem[ch][wp[ch] & 255] = word(ch, wp[ch]);
      wp[ch]++;
    end
    update_io();
  endtask

  // one clock: pops seen before the edge advance the FIFO model after it
  task automatic cyc();
    logic [2:0] p;
    p = ch_pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      if (p[i]) begin
        rp[i]++;
        pops[i]++;
      end
    update_io();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fmt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rp[i] = wp[i];
      exp_seq[i] = wp[i];
    end
    update_io();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // expects to be called in the first XFER cycle of the packet
  task automatic run_pkt(input int ch, input int n);
    for (int w = 0; w < n; w++) begin
      fmt_ready = 1'b1;
      #1;
      chk("pkt_valid", 32'(fmt_valid), 1);
      chk("pkt_chid", 32'(fmt_chid), ch);
      chk("pkt_data", fmt_data, word(ch, exp_seq[ch]));
      chk("pkt_sop", 32'(fmt_sop), 32'(w == 0));
      chk("pkt_eop", 32'(fmt_eop), 32'(w == n - 1));
      chk("pkt_pop", 32'(ch_pop), 32'(1 << ch));
      exp_seq[ch]++;
      cyc();
    end
    chk("gap_valid", 32'(fmt_valid), 0);
    chk("gap_busy", 32'(busy), 0);
    cyc();
  endtask

  initial begin
    int acc, k, p1;
    rst_n = 1'b0; fmt_ready = 1'b0;
    ch_en = 3'b111; ch_prio = '0; ch_len = '0;
    for (int i = 0; i < 3; i++) begin
      wp[i] = 0; rp[i] = 0; exp_seq[i] = 0; pops[i] = 0;
    end
    update_io();

    // reset held with everything eligible, then round-robin among equals
    do_reset();
    ch_len = {3'd1, 3'd1, 3'd1};
    rst_n = 1'b0;
    push(0, 4); push(1, 4); push(2, 4);
    for (int i = 0; i < 10; i++) cyc();
    chk("rst_valid", 32'(fmt_valid), 0);
    chk("rst_pop", 32'(ch_pop), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sop", 32'(fmt_sop), 0);
    rst_n = 1'b1;
    cyc();
    run_pkt(0, 2); run_pkt(1, 2); run_pkt(2, 2);
    run_pkt(0, 2); run_pkt(1, 2); run_pkt(2, 2);
    chk("rr_drained", 32'(fmt_valid), 0);

    // priority: ch2 highest, ch1 next, ch0 lowest
    do_reset();
    ch_prio = {2'd0, 2'd1, 2'd2};
    ch_len = {3'd3, 3'd3, 3'd3};
    push(2, 8); push(1, 4); push(0, 4);
    cyc();
    run_pkt(2, 4); run_pkt(2, 4); run_pkt(1, 4); run_pkt(0, 4);
    chk("prio_drained", 32'(fmt_valid), 0);
    ch_prio = '0;

    // backpressure on a 4-word ch1 packet: ready 1,0,0,1,1,1
    do_reset();
    push(1, 4);
    cyc();
    p1 = pops[1]; acc = 0; k = 0;
    while (acc < 4 && k < 12) begin
      fmt_ready = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      #1;
      chk("bp_valid", 32'(fmt_valid), 1);
      chk("bp_chid", 32'(fmt_chid), 1);
      chk("bp_data", fmt_data, word(1, exp_seq[1]));
      chk("bp_sop", 32'(fmt_sop), 32'(acc == 0));
      chk("bp_eop", 32'(fmt_eop), 32'(acc == 3));
      chk("bp_pop", 32'(ch_pop), fmt_ready ? 32'd2 : 32'd0);
      cyc();
      if (fmt_ready) begin
        acc++;
        exp_seq[1]++;
      end
      k++;
    end
    chk("bp_accepted", acc, 4);
    chk("bp_pops", pops[1] - p1, 4);
    chk("bp_cycles", k, 6);
    chk("bp_idle", 32'(fmt_valid), 0);
    fmt_ready = 1'b1;

    // eligibility threshold and mid-packet length change
    do_reset();
    push(0, 3);
    cyc(); cyc(); cyc();
    chk("elig_lvl3", 32'(fmt_valid), 0);
    push(0, 1);
    cyc();
    for (int w = 0; w < 4; w++) begin
      #1;
      chk("elig_valid", 32'(fmt_valid), 1);
      chk("elig_data", fmt_data, word(0, exp_seq[0]));
      chk("elig_sop", 32'(fmt_sop), 32'(w == 0));
      chk("elig_eop", 32'(fmt_eop), 32'(w == 3));
      exp_seq[0]++;
      cyc();
      if (w == 0) ch_len[2:0] = 3'd0;
    end
    chk("elig_end", 32'(fmt_valid), 0);
    ch_len = {3'd3, 3'd3, 3'd3};

    // reset after 2 of 8 words; remaining words stay and ch0 wins again
    do_reset();
    ch_len = {3'd1, 3'd1, 3'd7};
    push(0, 8); push(1, 2);
    cyc();
    for (int w = 0; w < 2; w++) begin
      #1;
      chk("mid_data", fmt_data, word(0, exp_seq[0]));
      chk("mid_sop", 32'(fmt_sop), 32'(w == 0));
      exp_seq[0]++;
      cyc();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pop", 32'(ch_pop), 0);
    cyc();
    chk("mid_valid", 32'(fmt_valid), 0);
    chk("mid_sop0", 32'(fmt_sop), 0);
    chk("mid_eop0", 32'(fmt_eop), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_fdata", fmt_data, 0);
    chk("mid_chid", 32'(fmt_chid), 0);
    chk("mid_level", 32'(ch_level[3:0]), 6);
    ch_len[2:0] = 3'd5;
    rst_n = 1'b1;
    cyc();
    run_pkt(0, 6);
    run_pkt(1, 2);
    chk("mid_drained", 32'(fmt_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
